// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded fields for the execute stage,
// detects load-use hazards against the instruction in decode, and inserts
// bubbles on branch flush or load-use stall while honouring downstream hold.
// Optional feature macro: ID_EX_PERF_EN enables a saturating bubble counter;
// without it bubble_cnt is tied to zero and no counter flops exist.
module id_ex_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 9,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic [1:0]        id_aluop,
  input  logic [5:0]        id_ctrl,
  input  logic              hold,
  input  logic              flush,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [RA_W-1:0]   ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic [1:0]        ex_aluop,
  output logic [5:0]        ex_ctrl,
  output logic              lu_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Bit position of memread inside {alusrc,memread,memwrite,memtoreg,regwrite,branch}
  localparam int unsigned CTRL_MEMREAD = 4;

  typedef enum logic [1:0] {
    ACT_CAPTURE,
    ACT_HOLD,
    ACT_BUBBLE
  } act_e;

  act_e act;

  logic              valid_q,  valid_d;
  logic [PC_W-1:0]   pc_q,     pc_d;
  logic [DATA_W-1:0] rd1_q,    rd1_d;
  logic [DATA_W-1:0] rd2_q,    rd2_d;
  logic [DATA_W-1:0] imm_q,    imm_d;
  logic [RA_W-1:0]   rs1_q,    rs1_d;
  logic [RA_W-1:0]   rs2_q,    rs2_d;
  logic [RA_W-1:0]   rd_q,     rd_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [6:0]        funct7_q, funct7_d;
  logic [1:0]        aluop_q,  aluop_d;
  logic [5:0]        ctrl_q,   ctrl_d;

  // Load-use hazard: load in EX writes a non-x0 register read by decode
  always_comb begin
    lu_stall = valid_q & ctrl_q[CTRL_MEMREAD] & (rd_q != '0) & id_valid &
               ((rd_q == id_rs1) | (rd_q == id_rs2)) & ~flush;
  end

  // Per-edge action: flush beats hold, hold beats load-use bubble
  always_comb begin
    act = ACT_CAPTURE;
    if (flush) begin
      act = ACT_BUBBLE;
    end else if (hold) begin
      act = ACT_HOLD;
    end else if (lu_stall) begin
      act = ACT_BUBBLE;
    end
  end

  // Next-state contents of the stage register
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    imm_d    = imm_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    funct3_d = funct3_q;
    funct7_d = funct7_q;
    aluop_d  = aluop_q;
    ctrl_d   = ctrl_q;
    unique case (act)
      ACT_BUBBLE: begin
        valid_d  = 1'b0;
        pc_d     = '0;
        rd1_d    = '0;
        rd2_d    = '0;
        imm_d    = '0;
        rs1_d    = '0;
        rs2_d    = '0;
        rd_d     = '0;
        funct3_d = '0;
        funct7_d = '0;
        aluop_d  = '0;
        ctrl_d   = '0;
      end
      ACT_CAPTURE: begin
        // An invalid decode slot keeps its fields but can never write or access memory
        valid_d  = id_valid;
        pc_d     = id_pc;
        rd1_d    = id_rd1;
        rd2_d    = id_rd2;
        imm_d    = id_imm;
        rs1_d    = id_rs1;
        rs2_d    = id_rs2;
        rd_d     = id_valid ? id_rd : '0;
        funct3_d = id_funct3;
        funct7_d = id_funct7;
        aluop_d  = id_aluop;
        ctrl_d   = id_valid ? id_ctrl : '0;
      end
      default: begin
      end
    endcase
  end

  // Stage register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
      aluop_q  <= '0;
      ctrl_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      funct3_q <= funct3_d;
      funct7_q <= funct7_d;
      aluop_q  <= aluop_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // Output wiring
  always_comb begin
    ex_valid  = valid_q;
    ex_pc     = pc_q;
    ex_rd1    = rd1_q;
    ex_rd2    = rd2_q;
    ex_imm    = imm_q;
    ex_rs1    = rs1_q;
    ex_rs2    = rs2_q;
    ex_rd     = rd_q;
    ex_funct3 = funct3_q;
    ex_funct7 = funct7_q;
    ex_aluop  = aluop_q;
    ex_ctrl   = ctrl_q;
  end

`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Count loaded bubbles, saturating at all-ones
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if ((act == ACT_BUBBLE) && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  // Bubble counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Counter output
  always_comb begin
    bubble_cnt = bubble_cnt_q;
  end
`else
  // Counter disabled: port tied off
  always_comb begin
    bubble_cnt = '0;
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed scenarios followed by random traffic,
// checked against a behavioural model of the ID/EX stage rules.
module tb_id_ex_stage_reg;

  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic        valid;
    logic [8:0]  pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [1:0]  aluop;
    logic [5:0]  ctrl;
  } fields_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0;
  logic flush = 1'b0;
  fields_t id = '0;
  fields_t act;
  logic lu_stall;
  logic [CNT_W-1:0] bubble_cnt;

  fields_t m_ex = '0;
  int unsigned m_cnt = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.DATA_W(32), .PC_W(9), .RA_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id.valid), .id_pc(id.pc), .id_rd1(id.rd1), .id_rd2(id.rd2),
    .id_imm(id.imm), .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
    .id_funct3(id.f3), .id_funct7(id.f7), .id_aluop(id.aluop), .id_ctrl(id.ctrl),
    .hold(hold), .flush(flush),
    .ex_valid(act.valid), .ex_pc(act.pc), .ex_rd1(act.rd1), .ex_rd2(act.rd2),
    .ex_imm(act.imm), .ex_rs1(act.rs1), .ex_rs2(act.rs2), .ex_rd(act.rd),
    .ex_funct3(act.f3), .ex_funct7(act.f7), .ex_aluop(act.aluop), .ex_ctrl(act.ctrl),
    .lu_stall(lu_stall), .bubble_cnt(bubble_cnt)
  );

  // Hazard: a valid load in EX targeting a non-zero register that decode reads
  function automatic logic model_stall();
    return m_ex.valid && m_ex.ctrl[4] && (m_ex.rd != 5'd0) && id.valid &&
           ((m_ex.rd == id.rs1) || (m_ex.rd == id.rs2)) && !flush;
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef ID_EX_PERF_EN
    return CNT_W'(m_cnt);
`else
    return '0;
`endif
  endfunction

  // Model of one clock edge, evaluated with the inputs present at that edge
  task automatic model_edge();
    logic bubble;
    bubble = flush || (!hold && model_stall());
    if (bubble) begin
      m_ex = '0;
      if (m_cnt < (2 ** CNT_W) - 1) m_cnt++;
    end else if (!hold) begin
      m_ex = id;
      if (!id.valid) begin
        m_ex.ctrl = '0;
        m_ex.rd = '0;
      end
    end
  endtask

  task automatic check_stall(input string tag);
    logic e;
    e = model_stall();
    checks++;
    assert (lu_stall === e) else begin
      errors++;
      $error("FAIL %s lu_stall observed %0b expected %0b", tag, lu_stall, e);
    end
  endtask

  task automatic check_regs(input string tag);
    logic [CNT_W-1:0] ec;
    ec = exp_cnt();
    checks++;
    assert (act === m_ex) else begin
      errors++;
      $error("FAIL %s ex_fields observed %h expected %h", tag, act, m_ex);
    end
    checks++;
    assert (bubble_cnt === ec) else begin
      errors++;
      $error("FAIL %s bubble_cnt observed %0d expected %0d", tag, bubble_cnt, ec);
    end
  endtask

  // Inputs already driven at a negedge; check stall, clock once, check results
  task automatic cycle(input string tag);
    #1 check_stall(tag);
    @(posedge clk);
    model_edge();
    #1 check_regs(tag);
    @(negedge clk);
  endtask

  task automatic rand_id();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    id = r[$bits(fields_t)-1:0];
  endtask

  task automatic set_lw(input logic [4:0] rd);
    rand_id();
    id.valid = 1'b1;
    id.aluop = 2'b00;
    id.f3 = 3'b010;
    id.ctrl = 6'b110110;
    id.rd = rd;
  endtask

  task automatic set_add(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    rand_id();
    id.valid = 1'b1;
    id.aluop = 2'b01;
    id.f3 = 3'b000;
    id.f7 = 7'b0000000;
    id.ctrl = 6'b000010;
    id.rs1 = rs1;
    id.rs2 = rs2;
    id.rd = rd;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    #1 check_regs("reset_init");
    check_stall("reset_init");
    rst_n = 1'b1;
    @(negedge clk);

    // Async reset mid-cycle with a valid instruction in EX
    set_add(5'd1, 5'd2, 5'd3);
    cycle("pre_reset_load");
    #2 rst_n = 1'b0;
    #1 m_ex = '0;
    m_cnt = 0;
    check_regs("async_reset");
    check_stall("async_reset");
    #1 rst_n = 1'b1;
    @(negedge clk);
    set_add(5'd4, 5'd5, 5'd6);
    cycle("first_after_reset");

    // Pass-through of an R-type subtract-like encoding
    rand_id();
    id.valid = 1'b1; id.aluop = 2'b01; id.f3 = 3'b000; id.f7 = 7'b0100000;
    id.rd1 = 32'd5; id.rd2 = 32'd3; id.ctrl = 6'b000010;
    cycle("pass_through");

    // Load-use on rs2: bubble, then the retried add is captured
    set_lw(5'd7);
    cycle("lw_rd7");
    set_add(5'd9, 5'd7, 5'd10);
    cycle("lu_bubble");
    cycle("lu_retry");

    // Load into x0 never stalls
    set_lw(5'd0);
    cycle("lw_x0");
    set_add(5'd0, 5'd0, 5'd11);
    cycle("x0_no_stall");

    // Flush beats hold and load-use
    set_lw(5'd7);
    cycle("lw_rd7_b");
    set_add(5'd7, 5'd1, 5'd12);
    flush = 1'b1; hold = 1'b1;
    cycle("flush_beats_hold");
    flush = 1'b0; hold = 1'b0;

    // Hold freezes EX while decode changes
    set_add(5'd1, 5'd2, 5'd13);
    cycle("before_hold");
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      cycle("hold");
    end
    // Hold with a pending load-use: no bubble counted
    set_lw(5'd8);
    hold = 1'b0;
    cycle("lw_rd8");
    set_add(5'd8, 5'd8, 5'd14);
    hold = 1'b1;
    cycle("hold_over_stall");
    hold = 1'b0;
    cycle("stall_after_hold");

    // Drive enough flushes to saturate the counter
    flush = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_id();
      cycle("flush_sat");
    end
    flush = 1'b0;

    // Random traffic with small register indices to provoke hazards
    for (int i = 0; i < 400; i++) begin
      rand_id();
      id.rs1 = 5'($urandom_range(0, 3));
      id.rs2 = 5'($urandom_range(0, 3));
      id.rd = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) id.ctrl[4] = 1'b1;
      if ($urandom_range(0, 4) == 0) id.valid = 1'b0; else id.valid = 1'b1;
      hold = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      cycle("random");
    end
    hold = 1'b0;
    flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
